// File: rtl/arith_seq_ctrl.sv
// arith_seq_ctrl: runs wide add/subtract operations one nibble at a time through a shared 4-bit mux/adder unit.
// Optional feature macro ARITH_SEQ_OVF_EN builds the signed-overflow flag; without it ovf is tied low.
module arith_seq_ctrl #(
  parameter int NIBBLES       = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic                 cin_in,
  input  logic [4*NIBBLES-1:0] opa,
  input  logic [4*NIBBLES-1:0] opb,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 ovf,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [1:0]           alu_s,
  output logic                 alu_cin,
  input  logic [3:0]           alu_d,
  input  logic                 alu_cout
);
  localparam logic [2:0] IDX_LAST = 3'(NIBBLES - 1);
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 carry_q, carry_d;
  logic [1:0]           op_q, op_d;
  logic [4*NIBBLES-1:0] opa_q, opa_d;
  logic [4*NIBBLES-1:0] opb_q, opb_d;
  logic [4*NIBBLES-1:0] result_q, result_d;
  logic                 cout_q, cout_d;

  logic accept, capture, last_nib;

  assign accept   = (state_q == IDLE) && start;
  assign capture  = (state_q == SETTLE) && (cnt_q == 4'd0);
  assign last_nib = (idx_q == IDX_LAST);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          opa_d    = opa;
          opb_d    = opb;
          op_d     = op;
          carry_d  = cin_in;
          idx_d    = 3'd0;
          cnt_d    = CNT_INIT;
          result_d = '0;
          cout_d   = 1'b0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (!capture) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == 3'(i)) result_d[4*i +: 4] = alu_d;
          end
          carry_d = alu_cout;
          if (last_nib) begin
            cout_d  = alu_cout;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 3'd1;
            cnt_d = CNT_INIT;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      cnt_q    <= 4'd0;
      carry_q  <= 1'b0;
      op_q     <= 2'd0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  // Unit inputs come straight from registers so they stay glitch-free for the whole settle window.
  always_comb begin
    alu_a = 4'd0;
    alu_b = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == 3'(i)) begin
        alu_a = opa_q[4*i +: 4];
        alu_b = opb_q[4*i +: 4];
      end
    end
  end

  assign alu_s   = op_q;
  assign alu_cin = carry_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign result  = result_q;
  assign cout    = cout_q;

`ifdef ARITH_SEQ_OVF_EN
  logic ovf_q, ovf_d, y_msb;

  always_comb begin
    case (op_q)
      2'b00:   y_msb = opb_q[4*NIBBLES-1];
      2'b01:   y_msb = ~opb_q[4*NIBBLES-1];
      2'b10:   y_msb = 1'b0;
      default: y_msb = 1'b1;
    endcase
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = 1'b0;
    end else if (capture && last_nib) begin
      ovf_d = (opa_q[4*NIBBLES-1] == y_msb) && (alu_d[3] != opa_q[4*NIBBLES-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Self-checking bench for arith_seq_ctrl: default instance plus a SETTLE_CYCLES=3 instance, each with a behavioural 4-bit unit.
module tb_arith_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, start3, cin_in;
  logic [1:0]  op;
  logic [15:0] opa, opb;

  logic        busy, done, cout, ovf, alu_cin, alu_cout;
  logic [15:0] result;
  logic [3:0]  alu_a, alu_b, alu_d;
  logic [1:0]  alu_s;

  logic        busy3, done3, cout3, ovf3, alu_cin3, alu_cout3;
  logic [15:0] result3;
  logic [3:0]  alu_a3, alu_b3, alu_d3;
  logic [1:0]  alu_s3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        co;
    logic        ov;
  } exp_t;
  exp_t sb[$];

  // Behavioural model of the external mux + 4-bit adder unit.
  function automatic logic [4:0] unit_model(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] s, input logic c);
    logic [3:0] y;
    case (s)
      2'b00:   y = b;
      2'b01:   y = ~b;
      2'b10:   y = 4'h0;
      default: y = 4'hF;
    endcase
    return {1'b0, a} + {1'b0, y} + {4'b0, c};
  endfunction

  assign {alu_cout,  alu_d}  = unit_model(alu_a,  alu_b,  alu_s,  alu_cin);
  assign {alu_cout3, alu_d3} = unit_model(alu_a3, alu_b3, alu_s3, alu_cin3);

  function automatic exp_t ref_op(input logic [1:0] o, input logic c,
                                  input logic [15:0] a, input logic [15:0] b);
    logic [15:0] y;
    logic [16:0] s;
    exp_t e;
    case (o)
      2'b00:   y = b;
      2'b01:   y = ~b;
      2'b10:   y = '0;
      default: y = '1;
    endcase
    s = {1'b0, a} + {1'b0, y} + {16'b0, c};
    e.res = s[15:0];
    e.co  = s[16];
`ifdef ARITH_SEQ_OVF_EN
    e.ov  = (a[15] == y[15]) && (s[15] != a[15]);
`else
    e.ov  = 1'b0;
`endif
    return e;
  endfunction

  arith_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cin_in(cin_in),
    .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
    .cout(cout), .ovf(ovf), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_cin(alu_cin), .alu_d(alu_d), .alu_cout(alu_cout)
  );

  arith_seq_ctrl #(.NIBBLES(4), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .op(op), .cin_in(cin_in),
    .opa(opa), .opb(opb), .busy(busy3), .done(done3), .result(result3),
    .cout(cout3), .ovf(ovf3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_s(alu_s3),
    .alu_cin(alu_cin3), .alu_d(alu_d3), .alu_cout(alu_cout3)
  );

  // Drives one start pulse (accepted at the following rising edge E0) and returns at the falling edge after E0.
  task automatic drive_op(input int which, input logic [1:0] o, input logic c,
                          input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    op = o; cin_in = c; opa = a; opb = b;
    if (which == 0) start = 1'b1; else start3 = 1'b1;
    sb.push_back(ref_op(o, c, a, b));
    @(negedge clk);
    start = 1'b0; start3 = 1'b0;
  endtask

  // Counts rising edges after E0 until done is seen; bounded.
  task automatic wait_done(input int which, output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      if ((which == 0 ? done : done3) === 1'b1) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, cout, ovf} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: busy/done/cout/ovf=%b expected 0000", {busy, done, cout, ovf});
    end
    n_checks++;
    if ({result, alu_a, alu_b, alu_s, alu_cin} !== 27'd0) begin
      n_fail++; $display("FAIL reset_data: result=%h alu_a=%h alu_b=%h alu_s=%b alu_cin=%b expected all 0",
                         result, alu_a, alu_b, alu_s, alu_cin);
    end
    n_checks++;
    if ({busy3, done3, result3} !== 18'd0) begin
      n_fail++; $display("FAIL reset_dut3: busy=%b done=%b result=%h expected 0", busy3, done3, result3);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset complete");
  endtask

  task automatic test_arith();
    logic [1:0]  t_op [5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    logic        t_c  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] t_a  [5] = '{16'h1234, 16'h0007, 16'h0005, 16'hFFFF, 16'h0000};
    logic [15:0] t_b  [5] = '{16'h0FFF, 16'h0005, 16'h0007, 16'h5A5A, 16'h1234};
    int cyc;
    exp_t e;
    for (int t = 0; t < 5; t++) begin
      drive_op(0, t_op[t], t_c[t], t_a[t], t_b[t]);
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL arith%0d_busy_e0: busy=%b expected 1", t, busy);
      end
      wait_done(0, cyc);
      n_checks++;
      if (cyc != 4) begin
        n_fail++; $display("FAIL arith%0d_latency: done after %0d edges expected 4", t, cyc);
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL arith%0d_busy_done: busy=%b expected 1", t, busy);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({result, cout, ovf} !== {e.res, e.co, e.ov}) begin
          n_fail++; $display("FAIL arith%0d_result: result=%h cout=%b ovf=%b expected %h %b %b",
                             t, result, cout, ovf, e.res, e.co, e.ov);
        end
      end
      @(negedge clk);
      n_checks++;
      if ({busy, done} !== 2'b00) begin
        n_fail++; $display("FAIL arith%0d_end: busy=%b done=%b expected 0 0", t, busy, done);
      end
      $display("arith op=%b cin=%b a=%h b=%h -> result=%h cout=%b", t_op[t], t_c[t], t_a[t], t_b[t], result, cout);
    end
  endtask

  task automatic test_settle3();
    logic [15:0] a0 = 16'hC3A5;
    logic [15:0] b0 = 16'h1E2D;
    exp_t e;
    drive_op(1, 2'b00, 1'b0, a0, b0);
    for (int k = 0; k < 12; k++) begin
      n_checks++;
      if ({alu_a3, alu_b3} !== {a0[4*(k/3) +: 4], b0[4*(k/3) +: 4]}) begin
        n_fail++; $display("FAIL settle3_hold_c%0d: alu_a=%h alu_b=%h expected %h %h",
                           k, alu_a3, alu_b3, a0[4*(k/3) +: 4], b0[4*(k/3) +: 4]);
      end
      if (k == 4) begin
        start3 = 1'b1; op = 2'b11; opa = 16'hFFFF; opb = 16'hFFFF; cin_in = 1'b1;
      end
      if (k == 5) start3 = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (done3 !== 1'b1) begin
      n_fail++; $display("FAIL settle3_done_e12: done=%b expected 1", done3);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({result3, cout3} !== {e.res, e.co}) begin
        n_fail++; $display("FAIL settle3_result: result=%h cout=%b expected %h %b", result3, cout3, e.res, e.co);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy3, result3} !== {1'b0, e.res}) begin
        n_fail++; $display("FAIL settle3_ignored_start: busy=%b result=%h expected 0 %h", busy3, result3, e.res);
      end
    end
    $display("settle3 a=%h b=%h -> result=%h", a0, b0, result3);
  endtask

  task automatic test_async_reset();
    int cyc;
    exp_t e;
    drive_op(0, 2'b01, 1'b1, 16'hAAAA, 16'h1111);
    repeat (2) @(negedge clk);
    n_checks++;
    if (result !== 16'h0099) begin
      n_fail++; $display("FAIL areset_partial: result=%h expected 0099", result);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, result, alu_a, alu_b, alu_s, alu_cin} !== 29'd0) begin
      n_fail++; $display("FAIL areset_immediate: busy=%b done=%b result=%h alu_a=%h alu_b=%h alu_s=%b alu_cin=%b expected all 0",
                         busy, done, result, alu_a, alu_b, alu_s, alu_cin);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive_op(0, 2'b00, 1'b0, 16'h0001, 16'h0001);
    wait_done(0, cyc);
    n_checks++;
    if (cyc != 4) begin
      n_fail++; $display("FAIL areset_latency: done after %0d edges expected 4", cyc);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({result, cout} !== {e.res, e.co}) begin
        n_fail++; $display("FAIL areset_result: result=%h cout=%b expected %h %b", result, cout, e.res, e.co);
      end
    end
    @(negedge clk);
    $display("async reset recovery 0001+0001 -> result=%h", result);
  endtask

  task automatic test_ovf();
    int cyc;
    exp_t e;
    drive_op(0, 2'b00, 1'b0, 16'h7FFF, 16'h0001);
    wait_done(0, cyc);
    n_checks++;
    if (cyc != 4) begin
      n_fail++; $display("FAIL ovf_latency: done after %0d edges expected 4", cyc);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({result, cout, ovf} !== {e.res, e.co, e.ov}) begin
        n_fail++; $display("FAIL ovf_result: result=%h cout=%b ovf=%b expected %h %b %b",
                           result, cout, ovf, e.res, e.co, e.ov);
      end
    end
    @(negedge clk);
    $display("ovf 7FFF+0001 -> result=%h cout=%b ovf=%b", result, cout, ovf);
  endtask

  initial begin
    start = 1'b0; start3 = 1'b0; op = 2'b00; cin_in = 1'b0; opa = '0; opb = '0;
    test_reset();
    test_arith();
    test_settle3();
    test_async_reset();
    test_ovf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
